ras_alloc_scheduler: RTL and testbench

Sequencing and arbitration front-end for the return-stack free-list allocator. It shares the allocator's single command slot between three requesters: push (allocate a node), pop (free the most recent node) and flush (return a whole chain on mispredict recovery). It also drives the allocator's initial fetch, tracks node occupancy, and enforces the allocator's one-command-per-cycle and post-flush recovery rules.

---
 rtl/ras_alloc_pkg.sv | 26 ++
 rtl/ras_occupancy_counter.sv | 49 ++++
 rtl/ras_alloc_scheduler.sv | 150 +++++++++++++++
 tb/tb_ras_alloc_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_alloc_pkg.sv
// Shared types and constants for the return-stack allocator front-end.
package ras_alloc_pkg;

    localparam int PKG_ADDR = 4;
    localparam int OCC_W    = PKG_ADDR + 1;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } sched_state_e;

    // Chain descriptor as the allocator expects it, most significant field first.
    typedef struct packed {
        logic [PKG_ADDR-1:0] previous;
        logic [PKG_ADDR-1:0] start;
        logic [PKG_ADDR-1:0] snd;
        logic [PKG_ADDR-1:0] end_node;
        logic [PKG_ADDR-1:0] next_node;
    } vec_desc_t;

    function automatic logic [PKG_ADDR-1:0] desc_start(input vec_desc_t d);
        return d.start;
    endfunction

endpackage

// File: rtl/ras_occupancy_counter.sv
// Node occupancy counter: one optional increment plus a multi-node decrement per
// cycle, clamped to [0, DEPTH], with full/empty flags derived from the count.
module ras_occupancy_counter
    import ras_alloc_pkg::*;
#(
    parameter int W     = OCC_W,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         add,
    input  logic [W-1:0] sub,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [W:0] raised;
    logic [W:0] next_count;

    // Apply the increment first so a merged flush+push nets out as count+1-len.
    always_comb begin
        raised = {1'b0, count} + {{W{1'b0}}, add};
        if (clr) begin
            next_count = '0;
        end else if ({1'b0, sub} >= raised) begin
            next_count = '0;
        end else begin
            next_count = raised - {1'b0, sub};
        end
        if (next_count > (W+1)'(DEPTH)) begin
            next_count = (W+1)'(DEPTH);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= next_count[W-1:0];
        end
    end

    assign full  = (count == W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ras_alloc_scheduler.sv
// Arbitrates the allocator's single command slot between flush, pop and push,
// sequences the allocator's initial fetch and the post-flush recovery bubble,
// and tracks how many nodes are currently handed out.
module ras_alloc_scheduler
    import ras_alloc_pkg::*;
#(
    parameter int ADDR          = 4,
    parameter int DEPTH         = 16,
    parameter int INITIAL_FETCH = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reinit_req,
    input  logic              push_req,
    output logic              push_gnt,
    output logic [ADDR-1:0]   push_addr,
    input  logic              pop_req,
    input  logic [ADDR-1:0]   pop_addr,
    output logic              pop_gnt,
    input  logic              flush_req,
    input  logic [5*ADDR-1:0] flush_desc,
    input  logic [ADDR:0]     flush_len,
    output logic              flush_gnt,
    output logic [ADDR:0]     occupancy,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              al_alloc,
    output logic              al_free,
    output logic              al_reset,
    output logic [ADDR-1:0]   al_reset_addr,
    output logic [ADDR-1:0]   al_free_addr,
    output logic              al_move_vector,
    output logic [5*ADDR-1:0] al_vec_desc,
    output logic              al_size_is_one,
    input  logic [ADDR-1:0]   al_alloc_addr
);

    sched_state_e    state;
    sched_state_e    state_next;
    logic            occ_clr;
    logic            occ_add;
    logic [ADDR:0]   occ_sub;
    logic [ADDR-1:0] chain_start;

    // The chain's first node is reused directly when a push merges with a flush.
    assign chain_start    = flush_desc[3*ADDR +: ADDR];
    assign al_reset_addr  = ADDR'(INITIAL_FETCH);
    assign al_free_addr   = pop_addr;
    assign al_vec_desc    = flush_desc;
    assign al_size_is_one = (flush_len == (ADDR+1)'(1));

    // State register; reset always restarts from the allocator fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one fetch cycle, one recovery cycle after every flush.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = RUN;
            RUN: begin
                if (reinit_req) begin
                    state_next = INIT;
                end else if (flush_req) begin
                    state_next = BUBBLE;
                end
            end
            BUBBLE:  state_next = reinit_req ? INIT : RUN;
            default: state_next = INIT;
        endcase
    end

    // Grants, allocator strobes and occupancy commands; everything is gated by
    // reset so nothing is emitted while it is asserted.
    always_comb begin
        push_gnt       = 1'b0;
        push_addr      = al_alloc_addr;
        pop_gnt        = 1'b0;
        flush_gnt      = 1'b0;
        busy           = 1'b0;
        al_alloc       = 1'b0;
        al_free        = 1'b0;
        al_reset       = 1'b0;
        al_move_vector = 1'b0;
        occ_clr        = 1'b0;
        occ_add        = 1'b0;
        occ_sub        = '0;
        if (!reset) begin
            case (state)
                INIT: begin
                    busy     = 1'b1;
                    al_reset = 1'b1;
                end
                BUBBLE: begin
                    busy    = 1'b1;
                    occ_clr = reinit_req;
                end
                RUN: begin
                    if (reinit_req) begin
                        occ_clr = 1'b1;
                    end else if (flush_req) begin
                        flush_gnt      = 1'b1;
                        al_move_vector = 1'b1;
                        occ_sub        = flush_len;
                        if (push_req) begin
                            push_gnt  = 1'b1;
                            al_alloc  = 1'b1;
                            push_addr = chain_start;
                            occ_add   = 1'b1;
                        end
                    end else if (pop_req && !empty) begin
                        pop_gnt = 1'b1;
                        al_free = 1'b1;
                        occ_sub = (ADDR+1)'(1);
                    end else if (push_req && !full) begin
                        push_gnt = 1'b1;
                        al_alloc = 1'b1;
                        occ_add  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ras_occupancy_counter #(
        .W     (ADDR + 1),
        .DEPTH (DEPTH)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .clr   (occ_clr),
        .add   (occ_add),
        .sub   (occ_sub),
        .count (occupancy),
        .full  (full),
        .empty (empty)
    );

    // A chain longer than the live node count means requester bookkeeping diverged.
    flush_len_check: assert property (@(posedge clk) disable iff (reset)
        flush_gnt |-> (flush_len <= occupancy));

endmodule

// File: tb/tb_ras_alloc_scheduler.sv
// Self-checking bench for ras_alloc_scheduler: directed literal scenarios followed
// by randomized traffic compared every cycle against a behavioural model.
module tb_ras_alloc_scheduler;
    import ras_alloc_pkg::*;

    localparam int ADDR          = 4;
    localparam int DEPTH         = 16;
    localparam int INITIAL_FETCH = 0;

    localparam int PH_FETCH   = 0;
    localparam int PH_READY   = 1;
    localparam int PH_RECOVER = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              reinit_req;
    logic              push_req;
    logic              push_gnt;
    logic [ADDR-1:0]   push_addr;
    logic              pop_req;
    logic [ADDR-1:0]   pop_addr;
    logic              pop_gnt;
    logic              flush_req;
    logic [5*ADDR-1:0] flush_desc;
    logic [ADDR:0]     flush_len;
    logic              flush_gnt;
    logic [ADDR:0]     occupancy;
    logic              full;
    logic              empty;
    logic              busy;
    logic              al_alloc;
    logic              al_free;
    logic              al_reset;
    logic [ADDR-1:0]   al_reset_addr;
    logic [ADDR-1:0]   al_free_addr;
    logic              al_move_vector;
    logic [5*ADDR-1:0] al_vec_desc;
    logic              al_size_is_one;
    logic [ADDR-1:0]   al_alloc_addr;

    int checks = 0;
    int passed = 0;

    // Model state: nodes handed out, and whether the scheduler is fetching,
    // ready for commands, or recovering from a flush.
    int m_occ   = 0;
    int m_phase = PH_FETCH;

    ras_alloc_scheduler #(
        .ADDR(ADDR), .DEPTH(DEPTH), .INITIAL_FETCH(INITIAL_FETCH)
    ) dut (
        .clk(clk), .reset(reset), .reinit_req(reinit_req),
        .push_req(push_req), .push_gnt(push_gnt), .push_addr(push_addr),
        .pop_req(pop_req), .pop_addr(pop_addr), .pop_gnt(pop_gnt),
        .flush_req(flush_req), .flush_desc(flush_desc), .flush_len(flush_len),
        .flush_gnt(flush_gnt), .occupancy(occupancy), .full(full), .empty(empty),
        .busy(busy), .al_alloc(al_alloc), .al_free(al_free), .al_reset(al_reset),
        .al_reset_addr(al_reset_addr), .al_free_addr(al_free_addr),
        .al_move_vector(al_move_vector), .al_vec_desc(al_vec_desc),
        .al_size_is_one(al_size_is_one), .al_alloc_addr(al_alloc_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Every cycle, at the falling edge: derive expected outputs from the model and
    // the present requests, compare, then advance the model by one cycle.
    always @(negedge clk) begin
        logic e_pg, e_pog, e_fg, e_alloc, e_free, e_mv, e_rst, e_busy;
        int e_paddr, cur_occ, nxt_occ, nxt_ph;
        vec_desc_t d;
        d = flush_desc;
        e_pg = 0; e_pog = 0; e_fg = 0; e_alloc = 0; e_free = 0; e_mv = 0;
        e_rst = 0; e_busy = 0;
        e_paddr = int'(al_alloc_addr);
        cur_occ = reset ? 0 : m_occ;
        nxt_occ = cur_occ;
        nxt_ph  = m_phase;
        if (reset) begin
            nxt_ph = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            e_rst = 1; e_busy = 1; nxt_ph = PH_READY;
        end else if (reinit_req) begin
            e_busy = (m_phase == PH_RECOVER);
            nxt_occ = 0; nxt_ph = PH_FETCH;
        end else if (m_phase == PH_RECOVER) begin
            e_busy = 1; nxt_ph = PH_READY;
        end else if (flush_req) begin
            e_fg = 1; e_mv = 1; nxt_ph = PH_RECOVER;
            nxt_occ = cur_occ - int'(flush_len);
            if (push_req) begin
                e_pg = 1; e_alloc = 1; e_paddr = int'(desc_start(d)); nxt_occ++;
            end
            if (nxt_occ < 0) nxt_occ = 0;
        end else if (pop_req && cur_occ > 0) begin
            e_pog = 1; e_free = 1; nxt_occ = cur_occ - 1;
        end else if (push_req && cur_occ < DEPTH) begin
            e_pg = 1; e_alloc = 1; nxt_occ = cur_occ + 1;
        end

        chk("m_push_gnt", push_gnt, e_pg);
        if (e_pg) chk("m_push_addr", push_addr, e_paddr);
        chk("m_pop_gnt", pop_gnt, e_pog);
        chk("m_flush_gnt", flush_gnt, e_fg);
        chk("m_al_alloc", al_alloc, e_alloc);
        chk("m_al_free", al_free, e_free);
        chk("m_al_move_vector", al_move_vector, e_mv);
        chk("m_al_reset", al_reset, e_rst);
        chk("m_busy", busy, e_busy);
        chk("m_occupancy", occupancy, cur_occ);
        chk("m_full", full, cur_occ == DEPTH);
        chk("m_empty", empty, cur_occ == 0);
        chk("m_size_is_one", al_size_is_one, flush_len == 1);
        chk("m_free_addr", al_free_addr, pop_addr);
        chk("m_vec_desc", al_vec_desc, flush_desc);
        chk("m_reset_addr", al_reset_addr, INITIAL_FETCH);

        m_occ   = nxt_occ;
        m_phase = nxt_ph;
    end

    initial begin
        vec_desc_t d;
        reset = 1; reinit_req = 0; push_req = 0; pop_req = 0; pop_addr = 0;
        flush_req = 0; flush_desc = 0; flush_len = 1; al_alloc_addr = 0;
        tick(); tick();

        // Reset held: nothing may be emitted even with a request pending.
        push_req = 1; settle();
        chk("rst_al_reset", al_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_push_gnt", push_gnt, 0);

        // Release: one fetch cycle, then the first push is granted.
        tick(); reset = 0; settle();
        chk("init_al_reset", al_reset, 1);
        chk("init_busy", busy, 1);
        chk("init_push_gnt", push_gnt, 0);
        tick(); al_alloc_addr = 4'h7; settle();
        chk("first_push_gnt", push_gnt, 1);
        chk("first_push_addr", push_addr, 7);
        chk("first_busy", busy, 0);
        tick(); settle();
        chk("first_occ", occupancy, 1);

        // Fill to DEPTH; the next push is held.
        repeat (15) begin tick(); al_alloc_addr = 4'($urandom); end
        settle();
        chk("fill_occ", occupancy, 16);
        chk("fill_full", full, 1);
        chk("fill_push_held", push_gnt, 0);
        tick(); pop_req = 1; pop_addr = 4'h3; settle();
        chk("full_pop_gnt", pop_gnt, 1);
        chk("full_pop_push_gnt", push_gnt, 0);
        chk("full_free_addr", al_free_addr, 3);
        tick(); pop_req = 0; settle();
        chk("after_pop_occ", occupancy, 15);
        chk("after_pop_push_gnt", push_gnt, 1);
        tick(); push_req = 0; settle();
        chk("refill_occ", occupancy, 16);

        // Reinit from RUN clears occupancy and refetches.
        tick(); reinit_req = 1; pop_req = 1; settle();
        chk("reinit_pop_gnt", pop_gnt, 0);
        tick(); reinit_req = 0; pop_req = 0; settle();
        chk("reinit_al_reset", al_reset, 1);
        chk("reinit_occ", occupancy, 0);

        // Pop beats push at occupancy 3.
        tick(); push_req = 1;
        repeat (3) tick();
        pop_req = 1; settle();
        chk("pp_occ", occupancy, 3);
        chk("pp_pop_gnt", pop_gnt, 1);
        chk("pp_push_gnt", push_gnt, 0);
        chk("pp_al_free", al_free, 1);
        tick(); pop_req = 0; settle();
        chk("pp_occ_after", occupancy, 2);
        chk("pp_push_next", push_gnt, 1);
        tick(); settle();
        chk("pp_occ_3", occupancy, 3);

        // Plain flush of 5 at occupancy 8, then one bubble.
        repeat (5) tick();
        push_req = 0; flush_req = 1; flush_len = 5; flush_desc = 20'h12345; settle();
        chk("fl_occ_before", occupancy, 8);
        chk("fl_flush_gnt", flush_gnt, 1);
        chk("fl_move_vector", al_move_vector, 1);
        chk("fl_al_alloc", al_alloc, 0);
        tick(); flush_req = 0; push_req = 1; settle();
        chk("fl_occ_after", occupancy, 3);
        chk("fl_bubble_busy", busy, 1);
        chk("fl_bubble_push", push_gnt, 0);
        tick(); settle();
        chk("fl_run_push", push_gnt, 1);
        chk("fl_run_busy", busy, 0);

        // Merged flush of 4 plus push at occupancy 6.
        repeat (3) tick();
        d = '{previous: 4'h1, start: 4'hA, snd: 4'hB, end_node: 4'hC, next_node: 4'hD};
        flush_desc = d; flush_len = 4; flush_req = 1; al_alloc_addr = 4'h2; settle();
        chk("mg_occ_before", occupancy, 6);
        chk("mg_push_gnt", push_gnt, 1);
        chk("mg_push_addr", push_addr, 4'hA);
        chk("mg_al_alloc", al_alloc, 1);
        chk("mg_move_vector", al_move_vector, 1);

        // Reinit during the bubble.
        tick(); flush_req = 0; push_req = 0; reinit_req = 1; settle();
        chk("mg_occ_after", occupancy, 3);
        chk("bub_busy", busy, 1);
        chk("bub_flush_gnt", flush_gnt, 0);
        tick(); reinit_req = 0; settle();
        chk("bub_reinit_al_reset", al_reset, 1);
        chk("bub_reinit_occ", occupancy, 0);

        // Asynchronous reset in the middle of a granted push.
        tick(); push_req = 1; tick(); settle();
        chk("ar_occ_before", occupancy, 1);
        chk("ar_push_gnt_before", push_gnt, 1);
        reset = 1; settle();
        chk("ar_push_gnt", push_gnt, 0);
        chk("ar_al_alloc", al_alloc, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_busy", busy, 0);
        chk("ar_al_reset", al_reset, 0);
        tick(); tick(); push_req = 0; reset = 0;

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset         = ($urandom_range(0, 299) == 0);
            reinit_req    = ($urandom_range(0, 39) == 0);
            push_req      = ($urandom_range(0, 9) < 6);
            pop_req       = ($urandom_range(0, 9) < 3);
            pop_addr      = 4'($urandom);
            al_alloc_addr = 4'($urandom);
            flush_desc    = 20'($urandom);
            if (m_occ > 0 && $urandom_range(0, 7) == 0) begin
                flush_req = 1;
                flush_len = 5'($urandom_range(1, m_occ));
            end else begin
                flush_req = 0;
                flush_len = 5'($urandom_range(1, DEPTH));
            end
        end
        tick();
        reset = 0; reinit_req = 0; push_req = 0; pop_req = 0; flush_req = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
